// File: rtl/apb_pkg.sv
// Shared types and constants for the multi-slave APB master.
package apb_pkg;

  localparam int unsigned APB_AW = 9;
  localparam int unsigned APB_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } apb_state_e;

  // Width of the slave-index field taken from the top address bits.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave-select decode: index from the top address bits, range check, one-hot select.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned NUM_SLV = 2,
  localparam int unsigned SW     = sel_width(NUM_SLV),
  localparam int unsigned IW     = (SW > 0) ? SW : 1
) (
  input  logic [AW-1:0]      addr,
  output logic [IW-1:0]      idx,
  output logic               valid,
  output logic [NUM_SLV-1:0] sel
);

  logic unused_addr;
  assign unused_addr = ^addr;

  if (SW > 0) begin : g_idx
    assign idx = addr[AW-1 -: SW];
  end else begin : g_idx0
    assign idx = '0;
  end

  // Non-power-of-two slave counts leave some index codes unmapped.
  assign valid = (32'(idx) < NUM_SLV);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (valid && (32'(idx) == i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_nslv.sv
// APB master driving NUM_SLV slaves through a one-hot PSEL, with wait-state
// timeout and a decode-error path for unmapped slave indices.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned NUM_SLV = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic [AW-1:0]         req_addr,
  input  logic                  req_write,
  input  logic [DW-1:0]         req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [AW-1:0]         PADDR,
  output logic                  PWRITE,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic [DW-1:0]         PWDATA,
  input  logic [NUM_SLV*DW-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int unsigned SW = sel_width(NUM_SLV);
  localparam int unsigned IW = (SW > 0) ? SW : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e         state_q, state_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [AW-1:0]      paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DW-1:0]      pwdata_q, pwdata_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CW-1:0]      wait_q, wait_d;

  logic [IW-1:0]      dec_idx;
  logic               dec_valid;
  logic [NUM_SLV-1:0] dec_sel;

  logic               sel_ready;
  logic               sel_err;
  logic [DW-1:0]      sel_rdata;
  logic [CW-1:0]      wait_inc;
  logic               timeout_hit;

  apb_addr_decode #(
    .AW      (AW),
    .NUM_SLV (NUM_SLV)
  ) u_addr_decode (
    .addr  (req_addr),
    .idx   (dec_idx),
    .valid (dec_valid),
    .sel   (dec_sel)
  );

  // Only the selected slave's response lines are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (32'(idx_q) == i) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DW +: DW];
      end
    end
  end

  assign wait_inc    = (wait_q == '1) ? wait_q : wait_q + CW'(1);
  // Abort on the edge where this wait cycle brings the count to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (32'(wait_inc) == TIMEOUT);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_d      = wait_q;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          idx_d    = dec_idx;
          if (dec_valid) begin
            state_d   = SETUP;
            psel_d    = dec_sel;
            penable_d = 1'b0;
            wait_d    = '0;
          end else begin
            state_d = DERR;
            psel_d  = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) begin
            state_d     = IDLE;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      DERR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready = (state_q == IDLE) && PRESETn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: a 2-slave instance (TIMEOUT=4) and a 3-slave
// instance (timeout disabled) sharing one bench-driven slave model.
module tb_apb_master_nslv;

  typedef struct {
    int         lat;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   vec = 0;
  int   errs = 0;
  int   cur = 0;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       transfer_a, transfer_b;
  logic [8:0] req_addr;
  logic       req_write;
  logic [7:0] req_wdata;
  logic [2:0] pready, pslverr;
  logic [23:0] prdata;

  logic       req_ready_a, rsp_valid_a, rsp_err_a, pwrite_a, penable_a;
  logic [7:0] rsp_rdata_a, pwdata_a;
  logic [8:0] paddr_a;
  logic [1:0] psel_a;
  logic       req_ready_b, rsp_valid_b, rsp_err_b, pwrite_b, penable_b;
  logic [7:0] rsp_rdata_b, pwdata_b;
  logic [8:0] paddr_b;
  logic [2:0] psel_b;

  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_pwrite, o_penable;
  logic [7:0] o_rsp_rdata, o_pwdata;
  logic [8:0] o_paddr;
  logic [2:0] o_psel;

  always #5 PCLK = ~PCLK;

  apb_master_nslv #(.AW(9), .DW(8), .NUM_SLV(2), .TIMEOUT(4)) u_dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer_a), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .PADDR(paddr_a), .PWRITE(pwrite_a), .PSEL(psel_a), .PENABLE(penable_a),
    .PWDATA(pwdata_a), .PRDATA(prdata[15:0]), .PREADY(pready[1:0]),
    .PSLVERR(pslverr[1:0])
  );

  apb_master_nslv #(.AW(9), .DW(8), .NUM_SLV(3), .TIMEOUT(0)) u_dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer_b), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .PADDR(paddr_b), .PWRITE(pwrite_b), .PSEL(psel_b), .PENABLE(penable_b),
    .PWDATA(pwdata_b), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  always_comb begin
    if (cur == 0) begin
      o_req_ready = req_ready_a; o_rsp_valid = rsp_valid_a; o_rsp_err = rsp_err_a;
      o_rsp_rdata = rsp_rdata_a; o_paddr = paddr_a; o_pwrite = pwrite_a;
      o_pwdata = pwdata_a; o_psel = {1'b0, psel_a}; o_penable = penable_a;
    end else begin
      o_req_ready = req_ready_b; o_rsp_valid = rsp_valid_b; o_rsp_err = rsp_err_b;
      o_rsp_rdata = rsp_rdata_b; o_paddr = paddr_b; o_pwrite = pwrite_b;
      o_pwdata = pwdata_b; o_psel = psel_b; o_penable = penable_b;
    end
  end

  // Protocol rules on both instances, every cycle of the run.
  task automatic protocol_monitor();
    logic [2:0] pa = '0, pb = '0;
    logic       ea = 1'b0, eb = 1'b0, ra = 1'b0, rb = 1'b0;
    logic [2:0] sa;
    forever begin
      @(negedge PCLK);
      sa = {1'b0, psel_a};
      vec++;
      if (!$onehot0(sa) || !$onehot0(psel_b)) begin
        errs++; $display("FAIL onehot: psel_a=%b psel_b=%b required one-hot-or-zero", psel_a, psel_b);
      end
      if (ra) begin
        vec++;
        if (penable_a !== 1'b1) begin errs++; $display("FAIL psel_rose_a: penable=%b required 1", penable_a); end
      end
      if (rb) begin
        vec++;
        if (penable_b !== 1'b1) begin errs++; $display("FAIL psel_rose_b: penable=%b required 1", penable_b); end
      end
      if (penable_a && !ea) begin
        vec++;
        if (psel_a == 2'b00) begin errs++; $display("FAIL penable_rise_a: psel=%b required nonzero", psel_a); end
      end
      if (penable_b && !eb) begin
        vec++;
        if (psel_b == 3'b000) begin errs++; $display("FAIL penable_rise_b: psel=%b required nonzero", psel_b); end
      end
      ra = |(sa & ~pa);
      rb = |(psel_b & ~pb);
      pa = sa; pb = psel_b; ea = penable_a; eb = penable_b;
    end
  endtask

  // One request on instance d; the bench plays the selected slave, which is
  // ready after 'waits' ACCESS wait cycles (never when waits >= 1000).
  task automatic xfer(input int d, input string name, input logic [8:0] addr, input logic wr,
                      input logic [7:0] wd, input int waits, input logic [7:0] rd,
                      input logic slverr, input logic [2:0] exp_psel, input int lat,
                      input logic exp_err, input logic [7:0] exp_rdata, input bit keep);
    exp_t e, got;
    bit   done;
    logic [2:0] epsel;
    logic epen;
    done = 1'b0;
    cur = d;
    req_addr = addr; req_write = wr; req_wdata = wd;
    for (int i = 0; i < 3; i++) begin
      pready[i] = !exp_psel[i];
      prdata[i*8 +: 8] = exp_psel[i] ? rd : ~rd;
      pslverr[i] = exp_psel[i] ? slverr : 1'b1;
    end
    if (d == 0) transfer_a = 1'b1; else transfer_b = 1'b1;
    #1;
    vec++;
    if (o_req_ready !== 1'b1) begin errs++; $display("FAIL %s req_ready: got %b required 1", name, o_req_ready); end
    @(posedge PCLK);
    e.lat = lat; e.err = exp_err; e.rdata = exp_rdata;
    sbq.push_back(e);
    #1;
    if (!keep) begin
      transfer_a = 1'b0; transfer_b = 1'b0;
      req_addr = ~addr; req_wdata = ~wd; req_write = ~wr;
    end
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge PCLK);
      epsel = (n < lat) ? exp_psel : 3'b000;
      epen  = (exp_psel != 3'b000) && (n >= 2) && (n < lat);
      vec++;
      if (o_psel !== epsel) begin errs++; $display("FAIL %s psel@%0d: got %b required %b", name, n, o_psel, epsel); end
      vec++;
      if (o_penable !== epen) begin errs++; $display("FAIL %s penable@%0d: got %b required %b", name, n, o_penable, epen); end
      vec++;
      if (o_paddr !== addr || o_pwrite !== wr || o_pwdata !== wd) begin
        errs++; $display("FAIL %s addr/data@%0d: got %h/%b/%h required %h/%b/%h", name, n, o_paddr, o_pwrite, o_pwdata, addr, wr, wd);
      end
      vec++;
      if (o_req_ready !== (n >= lat)) begin errs++; $display("FAIL %s req_ready@%0d: got %b required %b", name, n, o_req_ready, n >= lat); end
      if (o_rsp_valid === 1'b1) begin
        done = 1'b1;
        vec++;
        if (sbq.size() == 0) begin
          errs++; $display("FAIL %s rsp: got unexpected rsp_valid at %0d required none", name, n);
        end else begin
          got = sbq.pop_front();
          if (n != got.lat || o_rsp_err !== got.err || o_rsp_rdata !== got.rdata) begin
            errs++; $display("FAIL %s rsp: got cyc %0d err %b rdata %h required cyc %0d err %b rdata %h", name, n, o_rsp_err, o_rsp_rdata, got.lat, got.err, got.rdata);
          end
        end
      end else if (n == lat) begin
        done = 1'b1;
        vec++; errs++;
        $display("FAIL %s rsp: got no rsp_valid at %0d required 1", name, n);
        if (sbq.size() > 0) void'(sbq.pop_front());
      end
      for (int i = 0; i < 3; i++)
        if (exp_psel[i]) pready[i] = (waits < 1000) && (n >= 2 + waits);
    end
    if (!done) begin vec++; errs++; $display("FAIL %s timeout: got no response required one", name); end
    if (!keep) begin
      @(negedge PCLK);
      vec++;
      if (o_rsp_valid !== 1'b0 || o_rsp_err !== exp_err || o_rsp_rdata !== exp_rdata) begin
        errs++; $display("FAIL %s hold: got valid %b err %b rdata %h required 0 %b %h", name, o_rsp_valid, o_rsp_err, o_rsp_rdata, exp_err, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; transfer_a = 1'b0; transfer_b = 1'b0;
    req_addr = '0; req_write = 1'b0; req_wdata = '0;
    pready = 3'b111; pslverr = 3'b000; prdata = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      cur = d; #1;
      vec++;
      if ({o_psel, o_penable, o_paddr, o_pwrite, o_pwdata} !== 22'd0) begin
        errs++; $display("FAIL reset_apb%0d: got psel %b en %b addr %h wr %b wd %h required all 0", d, o_psel, o_penable, o_paddr, o_pwrite, o_pwdata);
      end
      vec++;
      if ({o_rsp_valid, o_rsp_err, o_rsp_rdata, o_req_ready} !== 11'd0) begin
        errs++; $display("FAIL reset_rsp%0d: got valid %b err %b rdata %h ready %b required all 0", d, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_req_ready);
      end
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    cur = 0;
  endtask

  task automatic test_zero_wait_write();
    xfer(0, "wr_zero_wait", 9'h105, 1'b1, 8'hA5, 0, 8'h00, 1'b0, 3'b010, 3, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_wait_read();
    xfer(0, "rd_3wait", 9'h012, 1'b0, 8'h00, 3, 8'h3C, 1'b0, 3'b001, 6, 1'b0, 8'h3C, 1'b0);
  endtask

  task automatic test_timeout();
    xfer(0, "timeout", 9'h0AA, 1'b0, 8'h00, 1000, 8'h99, 1'b0, 3'b001, 6, 1'b1, 8'h00, 1'b0);
    xfer(0, "rd_after_tmo", 9'h180, 1'b0, 8'h00, 1, 8'h77, 1'b0, 3'b010, 4, 1'b0, 8'h77, 1'b0);
    xfer(0, "wr_zero_rdata", 9'h101, 1'b1, 8'h5E, 0, 8'h33, 1'b0, 3'b010, 3, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    xfer(0, "b2b_first", 9'h0F0, 1'b0, 8'h00, 0, 8'hC3, 1'b0, 3'b001, 3, 1'b0, 8'hC3, 1'b1);
    xfer(0, "b2b_second", 9'h1F0, 1'b1, 8'h6D, 1, 8'h00, 1'b0, 3'b010, 4, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_slverr_reset();
    xfer(0, "rd_slverr", 9'h020, 1'b0, 8'h00, 0, 8'h11, 1'b1, 3'b001, 3, 1'b1, 8'h11, 1'b0);
    cur = 0;
    req_addr = 9'h150; req_write = 1'b0; req_wdata = 8'h00;
    pready = 3'b101; pslverr = 3'b000;
    transfer_a = 1'b1;
    @(posedge PCLK);
    #1 transfer_a = 1'b0;
    repeat (2) @(negedge PCLK);
    vec++;
    if (psel_a !== 2'b10 || penable_a !== 1'b1) begin
      errs++; $display("FAIL pre_reset_access: got psel %b en %b required 10 1", psel_a, penable_a);
    end
    #2 PRESETn = 1'b0;
    #1;
    vec++;
    if (psel_a !== 2'b00 || penable_a !== 1'b0) begin
      errs++; $display("FAIL reset_mid_sel: got psel %b en %b required 00 0", psel_a, penable_a);
    end
    vec++;
    if (paddr_a !== 9'h000 || pwrite_a !== 1'b0 || pwdata_a !== 8'h00) begin
      errs++; $display("FAIL reset_mid_addr: got %h %b %h required 000 0 00", paddr_a, pwrite_a, pwdata_a);
    end
    vec++;
    if ({rsp_valid_a, rsp_err_a, rsp_rdata_a, req_ready_a} !== 11'd0) begin
      errs++; $display("FAIL reset_mid_rsp: got valid %b err %b rdata %h ready %b required all 0", rsp_valid_a, rsp_err_a, rsp_rdata_a, req_ready_a);
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge PCLK);
      vec++;
      if (rsp_valid_a !== 1'b0 || psel_a !== 2'b00 || req_ready_a !== 1'b1) begin
        errs++; $display("FAIL post_reset@%0d: got valid %b psel %b ready %b required 0 00 1", n, rsp_valid_a, psel_a, req_ready_a);
      end
    end
    pready = 3'b111;
  endtask

  task automatic test_decode_b();
    xfer(1, "b_slave2_rd", 9'h100, 1'b0, 8'h00, 6, 8'h5A, 1'b0, 3'b100, 9, 1'b0, 8'h5A, 1'b0);
    xfer(1, "b_decode_err", 9'h1C0, 1'b0, 8'h00, 0, 8'hEE, 1'b0, 3'b000, 2, 1'b1, 8'h00, 1'b0);
    xfer(1, "b_slave1_wr", 9'h080, 1'b1, 8'h3A, 0, 8'h00, 1'b0, 3'b010, 3, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    fork
      protocol_monitor();
      begin
        #100000;
        $display("FAIL watchdog: got no end of run required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_timeout();
    test_back_to_back();
    test_slverr_reset();
    test_decode_b();
    vec++;
    if (sbq.size() != 0) begin errs++; $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter AW, default 9, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter NUM_SLV, default 2, slave count (1..16, need not be a power of two).
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum wait cycles in ACCESS (0 disables the timeout).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with these ports: PCLK input 1 clock; PRESETn input 1 async active-low reset.
REQ-006 SHALL have request ports: transfer input 1 request; req_addr input AW; req_write input 1; req_wdata input DW; req_ready output 1 request accepted when high with transfer.
REQ-007 SHALL have response ports: rsp_valid output 1 one-cycle completion pulse; rsp_rdata output DW; rsp_err output 1.
REQ-008 SHALL have APB ports: PADDR output AW; PWRITE output 1; PSEL output NUM_SLV, one-hot; PENABLE output 1; PWDATA output DW; PRDATA input NUM_SLV*DW, slave i at bits [i*DW +: DW]; PREADY input NUM_SLV; PSLVERR input NUM_SLV.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS and DERR.
REQ-010 SHALL drive req_ready = (state==IDLE) && PRESETn; all other outputs SHALL be registered.
REQ-011 SHALL, in IDLE with transfer=1, capture the address, write flag and write data into PADDR/PWRITE/PWDATA at that edge.
REQ-012 SHALL decode the slave index as req_addr[AW-1 -: SW], with SW = clog2(NUM_SLV) (SW=0 means index 0).
REQ-013 SHALL, for a valid index, move to SETUP, set PSEL[idx]=1 and keep PENABLE=0.
REQ-014 SHALL, for index >= NUM_SLV, move to DERR with no PSEL bit set.
REQ-015 SHALL, from DERR, return to IDLE next cycle with rsp_valid=1, rsp_err=1 and rsp_rdata=0.
REQ-016 SHALL move unconditionally from SETUP to ACCESS with PENABLE=1, holding PSEL, PADDR, PWRITE and PWDATA stable.
REQ-017 SHALL, in ACCESS, sample only PREADY/PRDATA/PSLVERR of the selected slave; the other slaves' inputs SHALL be ignored.
REQ-018 SHALL, on an ACCESS edge with PREADY[idx]=1, go to IDLE, clear PSEL/PENABLE, and pulse rsp_valid the following cycle with rsp_err=PSLVERR[idx].
REQ-019 SHALL, in that completion, set rsp_rdata=PRDATA[idx] for reads and 0 for writes.
REQ-020 SHALL count ACCESS cycles with PREADY[idx]=0 in a wait counter that saturates and is cleared on entering SETUP.
REQ-021 SHALL, when TIMEOUT>0 and the wait counter reaches TIMEOUT, abort: go to IDLE, clear PSEL/PENABLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-022 SHALL, when PREADY[idx] rises on the same edge the counter hits TIMEOUT, complete normally per REQ-018; PREADY wins.
REQ-023 SHALL give latency from acceptance edge k: PSEL high in cycle k+1, PENABLE in k+2, rsp_valid in k+3 with zero wait states, plus one cycle per wait state.
REQ-024 SHALL ignore transfer outside IDLE; the next request is accepted no earlier than the cycle rsp_valid is high.
REQ-025 SHALL hold rsp_rdata/rsp_err until the next completion; rsp_valid SHALL be high exactly one cycle per request.
REQ-026 SHALL keep PADDR/PWRITE/PWDATA at their last values in IDLE.

Reset
REQ-027 SHALL, while PRESETn=0, force state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0 and req_ready=0, asynchronously.
REQ-028 SHALL, on reset assertion mid-transfer, drop PSEL/PENABLE immediately and produce no rsp_valid for the aborted request.
REQ-029 SHALL accept a request on the first edge after PRESETn deasserts.

Structure
REQ-030 SHALL place the state enum, default AW/DW constants and a clog2-based slave-select width function in shared package apb_pkg.
REQ-031 SHALL implement address decode (index, valid flag, one-hot PSEL vector) in sub-module apb_addr_decode.

Verification
REQ-032 Zero-wait write, NUM_SLV=2: addr 0x105, wdata 0xA5 -> PSEL=2'b10 at k+1, PENABLE at k+2, rsp_valid at k+3, rsp_err=0.
REQ-033 Read from slave 0 with 3 wait states: addr 0x012, PRDATA0=0x3C -> rsp_valid at k+6, rsp_rdata=0x3C; PADDR stable throughout.
REQ-034 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; next transfer accepted.
REQ-035 NUM_SLV=3, AW=9, addr 0x1C0 (index 3) -> no PSEL asserted, rsp_valid two cycles after acceptance, rsp_err=1.
REQ-036 PSLVERR=1 on read completion, plus PRESETn pulsed low during the ACCESS of a second read -> first read: rsp_err=1. Second read: all outputs zero immediately, no rsp_valid.
REQ-037 The bench SHALL check throughout every scenario: $rose of any PSEL bit implies PENABLE next cycle, PSEL is one-hot-or-zero, and PENABLE never rises without PSEL.
